// File: rtl/lcd_char_ctrl_if.sv
// rtl/lcd_char_ctrl_if.sv - byte write channel into the character-LCD controller
interface lcd_char_ctrl_if;
   logic       wr_valid;
   logic       wr_ready;
   logic       wr_rs;
   logic [7:0] wr_data;

   modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_char_ctrl.sv
// rtl/lcd_char_ctrl.sv - HD44780-class LCD controller: power-up wait, init sequence, write FIFO drain
// Optional 4-bit bus build: define LCD_NIBBLE_MODE_EN
module lcd_char_ctrl #(
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned PWRUP_CYC    = 1500000,
   parameter int unsigned SETUP_CYC    = 10,
   parameter int unsigned EN_HIGH_CYC  = 50,
   parameter int unsigned CMD_WAIT_CYC = 4000,
   parameter int unsigned CLR_WAIT_CYC = 164000
) (
   input  logic             clk,
   input  logic             rst_n,
   lcd_char_ctrl_if.slave   wr,
   output logic             busy,
   output logic             init_done,
   output logic             lcd_rs,
   output logic             lcd_rw,
   output logic             lcd_en,
   output logic [7:0]       lcd_d
);
`ifdef LCD_NIBBLE_MODE_EN
   localparam bit          NIBBLE = 1'b1;
   localparam int unsigned N_INIT = 8;
`else
   localparam bit          NIBBLE = 1'b0;
   localparam int unsigned N_INIT = 4;
`endif

   localparam int unsigned PWRUP_N = (PWRUP_CYC    == 0) ? 1 : PWRUP_CYC;
   localparam int unsigned SETUP_N = (SETUP_CYC    == 0) ? 1 : SETUP_CYC;
   localparam int unsigned EN_N    = (EN_HIGH_CYC  == 0) ? 1 : EN_HIGH_CYC;
   localparam int unsigned CMD_N   = (CMD_WAIT_CYC == 0) ? 1 : CMD_WAIT_CYC;
   localparam int unsigned CLR_N   = (CLR_WAIT_CYC == 0) ? 1 : CLR_WAIT_CYC;
   localparam int unsigned MAX_AB  = (PWRUP_N > SETUP_N) ? PWRUP_N : SETUP_N;
   localparam int unsigned MAX_CD  = (EN_N > CMD_N) ? EN_N : CMD_N;
   localparam int unsigned MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned MAX_N   = (MAX_ABCD > CLR_N) ? MAX_ABCD : CLR_N;
   localparam int unsigned CW      = (MAX_N > 1) ? $clog2(MAX_N) : 1;
   localparam int unsigned AW      = $clog2(FIFO_DEPTH);

   // Counters hold "cycles remaining minus one" so the exit test is a compare with zero
   localparam logic [CW-1:0] PWRUP_LD = CW'(PWRUP_N - 1);
   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_N - 1);
   localparam logic [CW-1:0] EN_LD    = CW'(EN_N - 1);
   localparam logic [CW-1:0] CMD_LD   = CW'(CMD_N - 1);
   localparam logic [CW-1:0] CLR_LD   = CW'(CLR_N - 1);
   localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_PWRUP, S_INIT, S_IDLE, S_SETUP, S_PULSE, S_WAIT} state_t;

   // {single_nibble, byte}; single nibbles carry their value in the upper half
   function automatic logic [8:0] init_rom(input logic [3:0] idx);
`ifdef LCD_NIBBLE_MODE_EN
      case (idx)
         4'd0, 4'd1, 4'd2: init_rom = 9'h130;
         4'd3:             init_rom = 9'h120;
         4'd4:             init_rom = 9'h028;
         4'd5:             init_rom = 9'h00C;
         4'd6:             init_rom = 9'h006;
         default:          init_rom = 9'h001;
      endcase
`else
      case (idx)
         4'd0:    init_rom = 9'h038;
         4'd1:    init_rom = 9'h00C;
         4'd2:    init_rom = 9'h006;
         default: init_rom = 9'h001;
      endcase
`endif
   endfunction

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    init_idx_q, init_idx_d;
   logic          init_done_q, init_done_d;
   logic          busy_q, busy_d;
   logic          rs_q, rs_d;
   logic [7:0]    d_q, d_d;
   logic [3:0]    lo_nib_q, lo_nib_d;
   logic          lo_pend_q, lo_pend_d;
   logic          clr_q, clr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [8:0]    mem_q [FIFO_DEPTH];

   logic          pop, push, ld, ld_rs, ld_single, wr_ready_c;
   logic [7:0]    ld_byte;
   logic [8:0]    rom_word;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_idx_d  = init_idx_q;
      init_done_d = init_done_q;
      rs_d        = rs_q;
      d_d         = d_q;
      lo_nib_d    = lo_nib_q;
      lo_pend_d   = lo_pend_q;
      clr_d       = clr_q;
      pop         = 1'b0;
      ld          = 1'b0;
      ld_rs       = 1'b0;
      ld_single   = 1'b0;
      ld_byte     = 8'h00;
      rom_word    = init_rom(init_idx_q);

      case (state_q)
         S_PWRUP: begin
            if (cnt_q == '0) state_d = S_INIT;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_INIT: begin
            ld         = 1'b1;
            ld_single  = rom_word[8];
            ld_byte    = rom_word[7:0];
            init_idx_d = init_idx_q + 1'b1;
         end
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               ld      = 1'b1;
               ld_rs   = mem_q[rd_ptr_q][8];
               ld_byte = mem_q[rd_ptr_q][7:0];
            end
         end
         S_SETUP: begin
            if (cnt_q == '0) begin
               state_d = S_PULSE;
               cnt_d   = EN_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_PULSE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (NIBBLE && lo_pend_q) begin
               // Second nibble of a byte: its own setup and pulse, no execution wait yet
               d_d       = {lo_nib_q, 4'h0};
               lo_pend_d = 1'b0;
               state_d   = S_SETUP;
               cnt_d     = SETUP_LD;
            end else begin
               state_d = S_WAIT;
               cnt_d   = clr_q ? CLR_LD : CMD_LD;
            end
         end
         S_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!init_done_q && (init_idx_q != 4'(N_INIT))) begin
               state_d = S_INIT;
            end else begin
               init_done_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_PWRUP;
      endcase

      if (ld) begin
         rs_d      = ld_rs;
         d_d       = NIBBLE ? {ld_byte[7:4], 4'h0} : ld_byte;
         lo_nib_d  = ld_byte[3:0];
         lo_pend_d = !ld_single;
         clr_d     = !ld_rs && !ld_single && (ld_byte[7:2] == 6'd0) && (ld_byte[1:0] != 2'd0);
         state_d   = S_SETUP;
         cnt_d     = SETUP_LD;
      end

      // A pop this cycle frees a slot, so a full FIFO can still take a byte
      wr_ready_c = (count_q != DEPTH_C) || pop;
      push       = wr.wr_valid && wr_ready_c;
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      busy_d = (state_d != S_IDLE) || (count_d != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_PWRUP;
         cnt_q       <= PWRUP_LD;
         init_idx_q  <= 4'd0;
         init_done_q <= 1'b0;
         busy_q      <= 1'b0;
         rs_q        <= 1'b0;
         d_q         <= 8'h00;
         lo_nib_q    <= 4'h0;
         lo_pend_q   <= 1'b0;
         clr_q       <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_idx_q  <= init_idx_d;
         init_done_q <= init_done_d;
         busy_q      <= busy_d;
         rs_q        <= rs_d;
         d_q         <= d_d;
         lo_nib_q    <= lo_nib_d;
         lo_pend_q   <= lo_pend_d;
         clr_q       <= clr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {wr.wr_rs, wr.wr_data};
   end

   assign wr.wr_ready = wr_ready_c;
   assign busy        = busy_q;
   assign init_done   = init_done_q;
   assign lcd_rs      = rs_q;
   assign lcd_rw      = 1'b0;
   assign lcd_en      = (state_q == S_PULSE);
   assign lcd_d       = d_q;
endmodule

// File: tb/tb_lcd_char_ctrl.sv
// tb/tb_lcd_char_ctrl.sv - directed self-checking bench for lcd_char_ctrl (small timing parameters)
module tb_lcd_char_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       busy, init_done, lcd_rs, lcd_rw, lcd_en;
   logic [7:0] lcd_d;
   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc;

   always #5 clk = ~clk;

   lcd_char_ctrl_if wr_if ();

   lcd_char_ctrl #(
      .FIFO_DEPTH(4), .PWRUP_CYC(20), .SETUP_CYC(2),
      .EN_HIGH_CYC(3), .CMD_WAIT_CYC(8), .CLR_WAIT_CYC(30)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr(wr_if),
      .busy(busy), .init_done(init_done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .lcd_en(lcd_en), .lcd_d(lcd_d)
   );

   // cyc = number of rising edges since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   int         rise_cyc[$];
   logic [8:0] rise_val[$];
   int         width[$];
   int         done_cyc;
   int         last_rise;
   logic       en_prev, done_prev;

   always @(negedge clk) begin
      if (!rst_n) begin
         rise_cyc.delete(); rise_val.delete(); width.delete();
         done_cyc = -1; en_prev = 1'b0; done_prev = 1'b0; last_rise = 0;
      end else begin
         if (lcd_en && !en_prev) begin
            rise_cyc.push_back(cyc);
            rise_val.push_back({lcd_rs, lcd_d});
            last_rise = cyc;
         end
         if (!lcd_en && en_prev) width.push_back(cyc - last_rise);
         if (init_done && !done_prev) done_cyc = cyc;
         en_prev   = lcd_en;
         done_prev = init_done;
      end
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wr_if.wr_valid = 1'b0; wr_if.wr_rs = 1'b0; wr_if.wr_data = 8'h00;
      repeat (3) @(negedge clk);
      check_eq("rst_outputs", int'({busy, init_done, lcd_rs, lcd_rw, lcd_en, lcd_d}), 0);
      check_eq("rst_wr_ready", int'(wr_if.wr_ready), 1);
      rst_n = 1'b1;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic push(input logic rs, input logic [7:0] data, output int acc);
      int n;
      wr_if.wr_valid = 1'b1; wr_if.wr_rs = rs; wr_if.wr_data = data;
      n = 0;
      while (!wr_if.wr_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check_eq("push_timeout", n, 0);
      @(negedge clk);
      acc = cyc;
      wr_if.wr_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int n;
      logic [8:0] init_exp [4];
      logic [8:0] t3_val   [5];
      int         t3_cyc   [5];
      init_exp = '{9'h038, 9'h00C, 9'h006, 9'h001};
      t3_val   = '{9'h141, 9'h001, 9'h142, 9'h0C0, 9'h143};
      t3_cyc   = '{101, 115, 151, 165, 179};

      do_reset();
`ifdef LCD_NIBBLE_MODE_EN
      n = 0;
      while (!init_done && n < 2000) begin @(negedge clk); n++; end
      check_eq("nib_init_done", int'(init_done), 1);
      @(negedge clk);
      push(1'b1, 8'hA5, acc);
      wait_cyc(cyc + 40);
      check_eq("nib_rise_count", rise_cyc.size(), 14);
      if (rise_cyc.size() == 14) begin
         check_eq("nib_init0", int'(rise_val[0]), 'h030);
         check_eq("nib_init3", int'(rise_val[3]), 'h020);
         check_eq("nib_init4_hi", int'(rise_val[4]), 'h020);
         check_eq("nib_init4_lo", int'(rise_val[5]), 'h080);
         check_eq("nib_a5_hi", int'(rise_val[12]), 'h1A0);
         check_eq("nib_a5_lo", int'(rise_val[13]), 'h150);
         check_eq("nib_gap", rise_cyc[13] - rise_cyc[12], 5);
      end
`else
      // Init sequence with no writes
      wait_cyc(110);
      check_eq("init_rise_count", rise_cyc.size(), 4);
      for (int i = 0; i < 4 && i < rise_cyc.size(); i++) begin
         check_eq($sformatf("init_cyc%0d", i), rise_cyc[i], 23 + 14 * i);
         check_eq($sformatf("init_val%0d", i), int'(rise_val[i]), int'(init_exp[i]));
         check_eq($sformatf("init_width%0d", i), width[i], 3);
      end
      check_eq("init_done_cyc", done_cyc, 98);
      check_eq("idle_busy", int'(busy), 0);

      // Two character bytes after init
      push(1'b1, 8'h48, acc);
      check_eq("t2_push0_cyc", acc, 111);
      push(1'b1, 8'h49, acc);
      wait_cyc(170);
      check_eq("t2_rise_count", rise_cyc.size(), 6);
      if (rise_cyc.size() == 6) begin
         check_eq("t2_cyc0", rise_cyc[4], 114);
         check_eq("t2_gap", rise_cyc[5] - rise_cyc[4], 14);
         check_eq("t2_val0", int'(rise_val[4]), 'h148);
         check_eq("t2_val1", int'(rise_val[5]), 'h149);
         check_eq("t2_width0", width[4], 3);
         check_eq("t2_width1", width[5], 3);
      end

      // Five writes during power-up; fifth waits for the first pop
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push(t3_val[i][8], t3_val[i][7:0], acc);
         check_eq($sformatf("t3_acc%0d", i), acc, i + 1);
      end
      check_eq("t3_full_ready", int'(wr_if.wr_ready), 0);
      push(t3_val[4][8], t3_val[4][7:0], acc);
      check_eq("t3_acc4", acc, 99);
      check_eq("t3_still_full", int'(wr_if.wr_ready), 0);
      wait_cyc(200);
      check_eq("t3_rise_count", rise_cyc.size(), 9);
      for (int i = 0; i < 5 && i + 4 < rise_cyc.size(); i++) begin
         check_eq($sformatf("t3_cyc%0d", i), rise_cyc[i + 4], t3_cyc[i]);
         check_eq($sformatf("t3_val%0d", i), int'(rise_val[i + 4]), int'(t3_val[i]));
      end
      check_eq("t3_busy_end", int'(busy), 0);

      // Reset while a user byte is pulsing, with another byte still queued
      push(1'b1, 8'h55, acc);
      push(1'b1, 8'h56, acc);
      n = 0;
      while (!lcd_en && n < 50) begin @(negedge clk); n++; end
      check_eq("t4_en_seen", int'(lcd_en), 1);
      rst_n = 1'b0;
      #1;
      check_eq("t4_en_drop", int'(lcd_en), 0);
      check_eq("t4_init_done", int'(init_done), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(5);
      check_eq("t4_init_done_after", int'(init_done), 0);
      wait_cyc(110);
      check_eq("t4_rise_count", rise_cyc.size(), 4);
      if (rise_cyc.size() > 0) begin
         check_eq("t4_first_cyc", rise_cyc[0], 23);
         check_eq("t4_first_val", int'(rise_val[0]), 'h038);
      end
      check_eq("t4_done_cyc", done_cyc, 98);
      check_eq("t4_busy", int'(busy), 0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
